pc_fetch_unit: RTL



---
 rtl/pc_fetch_unit.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
// Instruction-fetch stage. It owns the program counter and issues one request
// at a time to instruction memory. It presents each fetched instruction to
// decode and holds it there until decode accepts it. A redirect from the
// branch comparator overrides everything else and produces a one-cycle flush.
//
// Handshakes (valid/ready): a transfer happens on a rising clk edge where both
// valid and ready are high. The valid side keeps its payload stable until that
// edge. The memory response channel has no ready signal, because the fetch
// unit always takes imem_rvalid while in WAIT.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   br_taken, br_target     redirect request and target from the comparator
//   imem_req, imem_addr     fetch request valid and address (addr = pc)
//   imem_ready              memory accepts the request this cycle
//   imem_rvalid, imem_rdata response valid and instruction word
//   id_ready                decode accepts the presented instruction
//   if_valid, if_instr,
//   if_pc                   instruction presented to decode and its address
//   flush                   one-cycle pulse the cycle after a redirect
//   dbg_state               current FSM state (0=FETCH, 1=WAIT, 2=HOLD)
module pc_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_STEP  = 16'd1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        br_taken,
  input  logic [15:0] br_target,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [15:0] imem_rdata,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc,
  output logic        flush,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] req_pc_q, req_pc_d;
  logic        discard_q, discard_d;
  logic        if_valid_q, if_valid_d;
  logic [15:0] if_instr_q, if_instr_d;
  logic [15:0] if_pc_q, if_pc_d;
  logic        flush_q, flush_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      req_pc_q   <= 16'h0000;
      discard_q  <= 1'b0;
      if_valid_q <= 1'b0;
      if_instr_q <= 16'h0000;
      if_pc_q    <= 16'h0000;
      flush_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      discard_q  <= discard_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
      flush_q    <= flush_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    discard_d  = discard_q;
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    flush_d    = br_taken;

    case (state_q)
      S_FETCH: begin
        if (imem_ready) begin
          req_pc_d  = pc_q;
          state_d   = S_WAIT;
          // A request accepted in the same cycle as a redirect is still
          // outstanding at memory, so its response has to be thrown away.
          discard_d = br_taken;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          discard_d = 1'b0;
          state_d   = S_FETCH;
          if (!discard_q && !br_taken) begin
            if_instr_d = imem_rdata;
            if_pc_d    = req_pc_q;
            if_valid_d = 1'b1;
            pc_d       = req_pc_q + PC_STEP;
            state_d    = S_HOLD;
          end
        end else if (br_taken) begin
          discard_d = 1'b1;
        end
      end
      S_HOLD: begin
        // A redirect drops the held instruction even if decode is ready.
        if (id_ready || br_taken) begin
          if_valid_d = 1'b0;
          state_d    = S_FETCH;
        end
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    // A redirect takes priority over the sequential pc update.
    if (br_taken) begin
      pc_d       = br_target;
      if_valid_d = 1'b0;
    end
  end

  // The request is gated by rst_n so that it drops as soon as reset asserts.
  assign imem_req  = rst_n && (state_q == S_FETCH);
  assign imem_addr = pc_q;
  assign if_valid  = if_valid_q;
  assign if_instr  = if_instr_q;
  assign if_pc     = if_pc_q;
  assign flush     = flush_q;
  assign dbg_state = state_q;

endmodule
